// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Round-robin scheduler sharing one 8N1 UART transmit line
//               between N_REQ byte requesters. Each granted byte is sent as
//               start bit, 8 data bits (LSB first) and stop bit, every bit
//               lasting OS baud_tick pulses.
// Ports       : clk        - system clock
//               rst        - asynchronous reset, active low
//               baud_tick  - single-clk pulse at OS x baud rate
//               req_valid  - per-requester byte-available flags
//               req_data   - packed bytes, requester i at [8i+7:8i]
//               req_ready  - one-hot accept pulse (only while idle)
//               tx         - serial line, idle high
//               busy       - frame in progress
//               grant_id   - requester whose frame is on the line
//               tx_done    - single-clk pulse at the end of the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int OS     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      baud_tick,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      tx_done
);

    localparam int c_ID_W   = $clog2(N_REQ);
    localparam int c_TICK_W = $clog2(OS);

    localparam logic [c_ID_W-1:0]   c_ID_LAST   = c_ID_W'(N_REQ - 1);
    localparam logic [c_ID_W-1:0]   c_ID_ONE    = c_ID_W'(1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OS - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [2:0]          c_BIT_LAST  = 3'(DATA_W - 1);
    localparam logic [2:0]          c_BIT_ONE   = 3'd1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic [1:0]          r_state,     w_state_nx;
    logic [c_TICK_W-1:0] r_tick,      w_tick_nx;
    logic [2:0]          r_bit,       w_bit_nx;
    logic [DATA_W-1:0]   r_shift,     w_shift_nx;
    logic [c_ID_W-1:0]   r_ptr,       w_ptr_nx;
    logic [N_REQ-1:0]    r_req_ready, w_ready_nx;
    logic                r_tx,        w_tx_nx;
    logic                r_busy,      w_busy_nx;
    logic [c_ID_W-1:0]   r_grant_id,  w_grant_id_nx;
    logic                r_tx_done,   w_done_nx;

    logic                w_any;
    logic [c_ID_W-1:0]   w_winner;
    logic [c_ID_W-1:0]   w_idx;
    logic [N_REQ-1:0]    w_onehot;
    logic [DATA_W-1:0]   w_sel_data;
    logic [c_ID_W-1:0]   w_ptr_adv;
    logic                w_term;
    logic                w_grant_ok;

    // Round-robin pick: first valid requester searching upward from r_ptr.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = c_ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
        w_onehot           = '0;
        w_onehot[w_winner] = 1'b1;
        w_sel_data         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_winner == c_ID_W'(k)) begin
                w_sel_data = req_data[k*DATA_W +: DATA_W];
            end
        end
        w_ptr_adv = (w_winner == c_ID_LAST) ? '0 : w_winner + c_ID_ONE;
    end

    // Next-state and next-output logic. Every output is a register, so the
    // values computed here are what the line shows in the following cycle.
    always_comb begin
        w_state_nx    = r_state;
        w_tick_nx     = r_tick;
        w_bit_nx      = r_bit;
        w_shift_nx    = r_shift;
        w_ptr_nx      = r_ptr;
        w_ready_nx    = '0;
        w_tx_nx       = r_tx;
        w_busy_nx     = r_busy;
        w_grant_id_nx = r_grant_id;
        w_done_nx     = 1'b0;
        w_grant_ok    = 1'b0;
        w_term        = baud_tick && (r_tick == c_TICK_LAST);

        case (r_state)
            c_S_IDLE: begin
                w_tx_nx   = 1'b1;
                w_busy_nx = 1'b0;
                if (r_req_ready != '0) begin
                    // Grant cycle: any tick here is deliberately not counted.
                    w_state_nx = c_S_START;
                    w_tick_nx  = '0;
                    w_tx_nx    = 1'b0;
                    w_busy_nx  = 1'b1;
                end else begin
                    w_grant_ok = 1'b1;
                end
            end
            c_S_START: begin
                if (baud_tick) begin
                    if (w_term) begin
                        w_tick_nx  = '0;
                        w_bit_nx   = '0;
                        w_state_nx = c_S_DATA;
                        w_tx_nx    = r_shift[0];
                    end else begin
                        w_tick_nx = r_tick + c_TICK_ONE;
                    end
                end
            end
            c_S_DATA: begin
                if (baud_tick) begin
                    if (w_term) begin
                        w_tick_nx = '0;
                        if (r_bit == c_BIT_LAST) begin
                            w_state_nx = c_S_STOP;
                            w_tx_nx    = 1'b1;
                        end else begin
                            w_bit_nx = r_bit + c_BIT_ONE;
                            w_tx_nx  = r_shift[w_bit_nx];
                        end
                    end else begin
                        w_tick_nx = r_tick + c_TICK_ONE;
                    end
                end
            end
            default: begin
                // STOP: once tx_done has been shown for a cycle, return to
                // IDLE and arbitrate on the same edge so consecutive frames
                // are separated by the single grant cycle only.
                if (r_tx_done) begin
                    w_state_nx = c_S_IDLE;
                    w_busy_nx  = 1'b0;
                    w_grant_ok = 1'b1;
                end else if (baud_tick) begin
                    if (w_term) begin
                        w_tick_nx = '0;
                        w_done_nx = 1'b1;
                    end else begin
                        w_tick_nx = r_tick + c_TICK_ONE;
                    end
                end
            end
        endcase

        if (w_grant_ok && w_any) begin
            w_ready_nx    = w_onehot;
            w_shift_nx    = w_sel_data;
            w_grant_id_nx = w_winner;
            w_ptr_nx      = w_ptr_adv;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_S_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_req_ready <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_grant_id  <= '0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_tick      <= w_tick_nx;
            r_bit       <= w_bit_nx;
            r_shift     <= w_shift_nx;
            r_ptr       <= w_ptr_nx;
            r_req_ready <= w_ready_nx;
            r_tx        <= w_tx_nx;
            r_busy      <= w_busy_nx;
            r_grant_id  <= w_grant_id_nx;
            r_tx_done   <= w_done_nx;
        end
    end

    assign req_ready = r_req_ready;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;
    assign tx_done   = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Self-checking bench for uart_tx_scheduler. Requesters are
//               byte queues; a reference model predicts arbitration order
//               and the expected line level for every counted baud tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int N           = 4;
    localparam int OS          = 16;
    localparam int FRAME_TICKS = 10 * OS;

    localparam int P_IDLE    = 0;
    localparam int P_GRANTED = 1;
    localparam int P_COUNT   = 2;
    localparam int P_AWAIT   = 3;

    logic           clk       = 1'b0;
    logic           rst       = 1'b0;
    logic           baud_tick = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic           tx;
    logic           busy;
    logic [1:0]     grant_id;
    logic           tx_done;

    uart_tx_scheduler #(.N_REQ(N), .DATA_W(8), .OS(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester byte queues and reference-model state.
    logic [7:0] rq [N][$];
    int         grant_log[$];
    int         m_ptr     = 0;
    int         phase     = P_IDLE;
    int         t         = 0;
    int         pop_id    = -1;
    logic [9:0] frame     = '1;
    logic [N-1:0] prev_valid = '0;
    int         gap_mode  = 0;
    int         gap_cnt   = 0;
    bit         gap_alt   = 1'b0;
    bit         arrive_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int total_q();
        int s = 0;
        for (int i = 0; i < N; i++) s += rq[i].size();
        return s;
    endfunction

    task automatic next_gap(output int g);
        if (gap_mode == 0) begin
            g = 3;
        end else if (gap_mode == 1) begin
            gap_alt = ~gap_alt;
            g = gap_alt ? 2 : 6;
        end else begin
            g = int'($urandom_range(0, 5));
        end
    endtask

    task automatic drive_inputs();
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_data[i*8 +: 8] = rq[i][0];
            end
        end
        prev_valid = req_valid;
    endtask

    // One clock: observe outputs just after the edge, advance the model,
    // then drive inputs for the cycle that ends at the next edge.
    task automatic cycle();
        int           w;
        int           r;
        logic [N-1:0] exp_rdy;
        @(posedge clk);
        #1;
        if (pop_id >= 0) begin
            void'(rq[pop_id].pop_front());
            pop_id = -1;
        end
        case (phase)
            P_IDLE: begin
                w = rr_pick(prev_valid, m_ptr);
                exp_rdy = '0;
                if (w >= 0) exp_rdy[w] = 1'b1;
                check("idle_outputs", {req_ready, tx_done, busy, tx}, {exp_rdy, 1'b0, 1'b0, 1'b1});
                if (w >= 0) begin
                    check("grant_id", 32'(grant_id), w);
                    frame  = {1'b1, rq[w][0], 1'b0};
                    m_ptr  = (w + 1) % N;
                    grant_log.push_back(w);
                    pop_id = w;
                    phase  = P_GRANTED;
                end
            end
            P_GRANTED: begin
                check("start_entry", {req_ready, tx_done, busy, tx}, {{N{1'b0}}, 1'b0, 1'b1, 1'b0});
                phase = P_COUNT;
                t     = 0;
            end
            P_AWAIT: begin
                check("stop_done", {req_ready, tx_done, busy, tx}, {{N{1'b0}}, 1'b1, 1'b1, 1'b1});
                phase = P_IDLE;
            end
            default: ;
        endcase

        if (arrive_en && $urandom_range(0, 99) == 0) begin
            r = int'($urandom_range(0, N - 1));
            if (rq[r].size() < 2) rq[r].push_back(8'($urandom));
        end
        drive_inputs();
        if (gap_cnt == 0) begin
            baud_tick = 1'b1;
            next_gap(gap_cnt);
        end else begin
            baud_tick = 1'b0;
            gap_cnt--;
        end
        if (phase == P_COUNT && baud_tick) begin
            check("line_bit", {tx_done, busy, tx}, {1'b0, 1'b1, frame[t / OS]});
            t++;
            if (t == FRAME_TICKS) phase = P_AWAIT;
        end
    endtask

    task automatic hold_reset(input int n, input bit toggle);
        rst       = 1'b0;
        baud_tick = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (toggle) req_valid = N'($urandom);
            check("reset_outputs", {grant_id, req_ready, tx_done, busy, tx},
                  {2'b00, {N{1'b0}}, 1'b0, 1'b0, 1'b1});
        end
        phase  = P_IDLE;
        t      = 0;
        pop_id = -1;
        m_ptr  = 0;
        drive_inputs();
        rst = 1'b1;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!(phase == P_IDLE && pop_id < 0 && total_q() == 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
        repeat (3) cycle();
    endtask

    task automatic check_order(input string tag, input int exp_q[$]);
        check({tag, "_count"}, grant_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++) begin
            check(tag, grant_log[i], exp_q[i]);
        end
    endtask

    initial begin
        int n;

        // Reset with valids toggling, then a quiet idle stretch.
        hold_reset(5, 1'b1);
        repeat (40) cycle();

        // Single byte from requester 0, tick every 4 clk.
        grant_log.delete();
        rq[0].push_back(8'hA5);
        run_until_idle(2000);
        check_order("single_order", '{0});

        // Round robin from a fresh pointer.
        hold_reset(2, 1'b0);
        grant_log.delete();
        rq[0].push_back(8'h11);
        rq[1].push_back(8'h22);
        rq[2].push_back(8'h33);
        rq[3].push_back(8'h44);
        run_until_idle(4000);
        check_order("rr_order", '{0, 1, 2, 3});

        // Pointer moved to 2 by a grant to requester 1, then valids 1011.
        rq[1].push_back(8'($urandom));
        run_until_idle(2000);
        grant_log.delete();
        rq[0].push_back(8'($urandom));
        rq[1].push_back(8'($urandom));
        rq[3].push_back(8'($urandom));
        run_until_idle(4000);
        check_order("rr_ptr2_order", '{3, 0, 1});

        // Back-to-back frames from requester 1.
        grant_log.delete();
        for (int i = 0; i < 4; i++) rq[1].push_back(8'($urandom));
        run_until_idle(4000);
        check_order("b2b_order", '{1, 1, 1, 1});

        // Reset during data bit 3 of 8'hFF; requesters 0 and 2 pending.
        rq[1].push_back(8'hFF);
        n = 0;
        while (phase != P_COUNT && n < 100) begin cycle(); n++; end
        check("abort_grant_seen", 32'(phase == P_COUNT), 32'd1);
        rq[0].push_back(8'($urandom));
        rq[2].push_back(8'($urandom));
        n = 0;
        while (!(phase == P_COUNT && t >= 4 * OS + 6) && n < 1000) begin cycle(); n++; end
        check("abort_point_reached", 32'(n < 1000), 32'd1);
        #2 rst = 1'b0;
        #1 check("async_abort", {req_ready, tx_done, busy, tx}, {{N{1'b0}}, 1'b0, 1'b0, 1'b1});
        hold_reset(3, 1'b0);
        grant_log.delete();
        run_until_idle(4000);
        check_order("post_reset_order", '{0, 2});

        // Irregular tick spacing with a tick forced onto the grant cycle.
        gap_mode = 1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (gap_cnt != 1 && n < 20) begin cycle(); n++; end
            rq[k].push_back(8'($urandom));
            run_until_idle(3000);
        end

        // Random arrivals with random tick spacing.
        gap_mode  = 2;
        arrive_en = 1'b1;
        repeat (6000) cycle();
        arrive_en = 1'b0;
        run_until_idle(9000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART serial transmit line between N_REQ byte requesters using round-robin arbitration. It consumes the 16x oversampling pulse from the baud tick generator and sequences each granted byte into a standard 8N1 frame. It sits between the baud tick generator and the top-level tx pin, and replaces per-client transmitters.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, bits per character (fixed 8 for 8N1; other values not supported)
OS, 16, baud_tick pulses per serial bit

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
baud_tick  input  1  single-clk pulse at OS x baud rate
req_valid  input  N_REQ  per-requester byte-available flag
req_data  input  N_REQ*8  packed bytes; requester i occupies bits [8i+7:8i]
req_ready  output  N_REQ  one-hot grant/accept pulse
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress
grant_id  output  $clog2(N_REQ)  index of the requester whose frame is on the line
tx_done  output  1  single-clk pulse at the end of the stop bit

Behaviour:
- Reset (rst=0, async): tx=1, busy=0, req_ready=0, grant_id=0, tx_done=0, FSM=IDLE, tick/bit counters=0, round-robin pointer=0 (requester 0 has highest priority). Reset mid-frame aborts the frame; tx goes high immediately. No partial frame resumes.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: tx=1, busy=0. If any req_valid is 1, the winner is the first set bit searching from pointer upward with wrap. In that cycle:
  - assert req_ready[winner]=1 for exactly one clk;
  - latch req_data[winner] into the shift register;
  - set grant_id=winner;
  - set pointer=(winner+1) mod N_REQ;
  - go to START next clk.
  If no req_valid is set, stay in IDLE and leave the pointer unchanged.
- Handshake: a byte transfers on req_valid & req_ready. The requester holds valid and data stable until ready. At most one ready bit is high per cycle. ready is never high outside IDLE.
- START: tx=0, busy=1. Tick counter increments on each baud_tick. On the baud_tick where the count equals OS-1, reset the counter and go to DATA with bit index 0.
- DATA: tx=shift_reg[bit index], LSB first. The bit advances on the OS-th tick. After bit 7 completes, go to STOP.
- STOP: tx=1, busy=1. On the OS-th tick:
  - pulse tx_done for one clk;
  - go to IDLE.
  The earliest next grant is the following clk, so back-to-back frames have no extra idle bit.
- baud_tick pulses in IDLE or in the grant cycle are ignored. Counting starts on the first tick after entering START.
- Frame length: exactly 10*OS baud_tick pulses from START entry to STOP exit. The start edge may lag the grant by up to one tick period.
- grant_id holds its value through IDLE until the next grant.
- busy deasserts in the same clk that FSM returns to IDLE, which is the clk after the tx_done pulse.
- tx and all outputs are registered, with no combinational path from inputs.
- Counters: tick counter $clog2(OS) bits; bit index 3 bits. Neither wraps outside its terminal-count transition.

Test Plan:
- Reset idle: hold rst=0 for 5 clk, then release with no valids -> tx=1, busy=0, req_ready=0 indefinitely, and all 4 valids toggling during reset produce no grant.
- Single byte: baud_tick every 4 clk, req_valid=4'b0001, data0=8'hA5 -> req_ready=4'b0001 for 1 clk. tx then shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 16 ticks (64 clk). tx_done pulses once, grant_id=0.
- Round-robin: all four valid with bytes 8'h11/22/33/44, each requester dropping valid after its ready -> frames in order 0,1,2,3. Repeating with pointer=2 (after grant 1) and valid=4'b1011 gives order 3,0,1.
- Back-to-back: req 1 holds valid with a new byte after each ready -> next START begins the clk after IDLE re-entry. Each stop bit is exactly 16 ticks with no extra idle time, and busy drops for exactly 1 clk between frames.
- Mid-frame reset: assert rst=0 during DATA bit 3 of 8'hFF -> tx=1 and busy=0 asynchronously. After release, pointer=0, and a pending valid on req 2 is granted with a full fresh frame.
- Tick alignment: a baud_tick coincident with the grant cycle is not counted -> the start bit spans exactly 16 subsequent ticks, checked with an irregular tick spacing of 3 and 7 clk alternating.
